// File: rtl/generic_pack.sv
// Shared constants and helpers used across the video pipeline.
package generic_pack;

    localparam logic [23:0] LFSR_SEED = 24'hACE1B5;
    // Galois mask for x^24 + x^23 + x^22 + x^17 + 1
    localparam logic [23:0] LFSR_TAPS = 24'hE10000;

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {1'b0, s[23:1]} ^ (s[0] ? LFSR_TAPS : 24'h000000);
    endfunction

endpackage

// File: rtl/vfp_structs_pack.sv
// Pixel-stream types shared by the VFP source and sink blocks.
package vfp_structs_pack;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LFSR  = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } src_state_e;

    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/rgb_pattern_gen.sv
// Combinational RGB for the selected test pattern at the current pixel.
module rgb_pattern_gen
    import vfp_structs_pack::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [2:0]  bar_idx,
    input  logic [23:0] lfsr,
    input  pattern_e    pattern_sel,
    output logic [23:0] rgb
);

    logic [11:0] sum;
    assign sum = x + y;

    always_comb begin
        rgb = 24'h000000;
        unique case (pattern_sel)
            PAT_BARS:  rgb = BAR_COLORS[bar_idx];
            PAT_RAMP:  rgb = {x[7:0], y[7:0], sum[7:0]};
            PAT_CHECK: rgb = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
            PAT_LFSR:  rgb = lfsr;
        endcase
    end

endmodule

// File: rtl/rgb_pattern_source.sv
// Raster test-pattern source: frame FSM, counters, LFSR, registered outputs.
module rgb_pattern_source
    import vfp_structs_pack::*;
    import generic_pack::*;
#(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300,
    parameter int H_BLANK    = 16,
    parameter int V_BLANK    = 4
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_frames,
    input  logic [1:0]  pattern_sel,
    input  logic        hold,
    output logic        valid,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic [11:0] x_coord,
    output logic [11:0] y_coord,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        busy,
    output logic        seq_done
);

    localparam logic [11:0] X_LAST   = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST   = 12'(IMG_HEIGHT - 1);
    localparam logic [11:0] BAR_LAST = 12'(IMG_WIDTH / 8 - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST  = 16'(V_BLANK - 1);

    src_state_e  state;
    logic [11:0] x, y;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [23:0] lfsr;
    pattern_e    pat_q;
    logic [7:0]  num_q;
    logic [7:0]  fcnt;
    logic [15:0] bcnt;
    logic        hold_q;
    logic [23:0] rgb;

    rgb_pattern_gen u_gen (
        .x           (x),
        .y           (y),
        .bar_idx     (bar_idx),
        .lfsr        (lfsr),
        .pattern_sel (pat_q),
        .rgb         (rgb)
    );

    always_ff @(posedge pixclk) begin
        if (!reset) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            bar_cnt  <= '0;
            bar_idx  <= '0;
            lfsr     <= LFSR_SEED;
            pat_q    <= PAT_BARS;
            num_q    <= '0;
            fcnt     <= '0;
            bcnt     <= '0;
            hold_q   <= 1'b0;
            valid    <= 1'b0;
            oRed     <= '0;
            oGreen   <= '0;
            oBlue    <= '0;
            x_coord  <= '0;
            y_coord  <= '0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            eof      <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            hold_q   <= hold;
            valid    <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            eof      <= 1'b0;
            seq_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ACTIVE;
                        busy    <= 1'b1;
                        num_q   <= num_frames;
                        fcnt    <= '0;
                        pat_q   <= pattern_e'(pattern_sel);
                        x       <= '0;
                        y       <= '0;
                        bar_cnt <= '0;
                        bar_idx <= '0;
                        lfsr    <= LFSR_SEED;
                    end
                end
                S_ACTIVE: begin
                    if (!hold_q) begin
                        valid   <= 1'b1;
                        {oRed, oGreen, oBlue} <= rgb;
                        x_coord <= x;
                        y_coord <= y;
                        sof     <= (x == 12'd0) && (y == 12'd0);
                        eol     <= (x == X_LAST);
                        eof     <= (x == X_LAST) && (y == Y_LAST);
                        lfsr    <= lfsr_step(lfsr);
                        if (x == X_LAST) begin
                            x       <= '0;
                            bar_cnt <= '0;
                            bar_idx <= '0;
                            bcnt    <= '0;
                            state   <= (y == Y_LAST) ? S_VBLANK : S_HBLANK;
                        end else begin
                            x <= x + 12'd1;
                            // last bar keeps counting and absorbs the remainder
                            if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
                                bar_idx <= bar_idx + 3'd1;
                                bar_cnt <= '0;
                            end else begin
                                bar_cnt <= bar_cnt + 12'd1;
                            end
                        end
                    end
                end
                S_HBLANK: begin
                    if (bcnt == HB_LAST) begin
                        state <= S_ACTIVE;
                        y     <= y + 12'd1;
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
                S_VBLANK: begin
                    if (bcnt == VB_LAST) begin
                        if (num_q == 8'd0 || 8'(fcnt + 8'd1) != num_q) begin
                            state <= S_ACTIVE;
                            fcnt  <= fcnt + 8'd1;
                            y     <= '0;
                            lfsr  <= LFSR_SEED;
                            pat_q <= pattern_e'(pattern_sel);
                        end else begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/rgb_pattern_source.md
# rgb_pattern_source

Synthesizable raster pixel source on `pixclk`. It emits frames of 24-bit RGB pixels with a `valid` strobe, programmable horizontal and vertical blanking, and a selectable test pattern. It is the transmit end of the pixel-stream interface whose receive end counts x/y coordinates and logs pixels. In the VFP bench it drives the DUT's `valid`/`iRed`/`iGreen`/`iBlue` inputs in place of the camera front end, so frames are reproducible without BMP files.

## Interface
Parameters:
- `IMG_WIDTH`, 400: active pixels per line, range 8..4095.
- `IMG_HEIGHT`, 300: active lines per frame, range 1..4095.
- `H_BLANK`, 16: invalid cycles after each line except the last, minimum 1.
- `V_BLANK`, 4: invalid cycles after the last line of a frame, minimum 1.

Ports:
- `pixclk` in 1: pixel clock.
- `reset` in 1: synchronous, active-low.
- `start` in 1: begin a frame sequence; honoured in IDLE only.
- `num_frames` in 8: frames to send, latched at `start`; 0 means continuous.
- `pattern_sel` in 2: pattern select, latched at each frame start. 0 = colour bars, 1 = ramp, 2 = checker, 3 = LFSR.
- `hold` in 1: back-pressure; freezes active-pixel emission.
- `valid` out 1: pixel strobe.
- `oRed`, `oGreen`, `oBlue` out 8 each: pixel data.
- `x_coord` out 12, `y_coord` out 12: coordinates of the current pixel.
- `sof` out 1: high with pixel (0,0).
- `eol` out 1: high with pixel x = IMG_WIDTH-1.
- `eof` out 1: high with the last pixel of the frame.
- `busy` out 1: high in any state other than IDLE.
- `seq_done` out 1: one-cycle pulse when a finite sequence completes.

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE → ACTIVE on `start`.
  - ACTIVE → HBLANK after the `eol` pixel on a line that is not the last.
  - ACTIVE → VBLANK after the `eof` pixel.
  - HBLANK → ACTIVE after H_BLANK cycles, with y incremented and x = 0.
  - VBLANK → ACTIVE after V_BLANK cycles if more frames remain or `num_frames` = 0; otherwise → IDLE with a `seq_done` pulse.
- In ACTIVE with `hold` low: one pixel per cycle, x increments.
- In ACTIVE with `hold` high: `valid` is 0 and x, y, LFSR and the bar counter are frozen.
- `hold` has no effect in either blanking state; the blank counters keep running.
- Colour bars:
  - 8 bars, each IMG_WIDTH/8 pixels wide (floor); the last bar absorbs the remainder.
  - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Bar index comes from a width counter; no divider.
- Ramp: R = x[7:0], G = y[7:0], B = (x+y)[7:0], with 8-bit wrap.
- Checker: 8×8 cells. All channels FF when (x[3]^y[3]) = 1, else 00.
- LFSR:
  - 24-bit Galois, taps x^24+x^23+x^22+x^17+1.
  - Reseeded to 0xACE1B5 at every frame start; advances once per emitted pixel.
  - Output: R = lfsr[23:16], G = lfsr[15:8], B = lfsr[7:0].
- `start` is ignored while `busy`. `pattern_sel` changes mid-frame take effect at the next frame.
- Frame counter is 8 bits. In continuous mode it does not stop the sequence; it may wrap.

## Timing
- All outputs are registered.
- Reset values: all outputs 0 (`valid`, data, coordinates, `sof`, `eol`, `eof`, `busy`, `seq_done`), state IDLE, LFSR = seed.
- `start` high at edge T: pixel (0,0) with `valid` = 1 and `sof` = 1 is presented after edge T+1; `busy` = 1 from the same edge.
- `hold` sampled high at edge t: `valid` = 0 after edge t+1. Release is symmetric, and the first pixel after release is the frozen (next) pixel.
- Line period without hold: IMG_WIDTH + H_BLANK cycles.
- Frame period: IMG_HEIGHT·IMG_WIDTH + (IMG_HEIGHT-1)·H_BLANK + V_BLANK cycles.
- IMG_HEIGHT = 1: `eol` and `eof` fire together, followed directly by VBLANK.
- `seq_done` pulses on the edge that enters IDLE; `busy` drops on that same edge.
- Outside valid pixels, `sof`, `eol` and `eof` are 0, and data holds its last value.
- Reset asserted mid-frame: every output is at its reset value after the next edge. No partial-line completion.

## Structure
- Pattern-select enum and colour-bar constant array go in `vfp_structs_pack`.
- LFSR seed and taps go in `generic_pack`.
- Pattern datapath is one sub-module, `rgb_pattern_gen`. Its inputs are x, y, the bar index, the LFSR state and `pattern_sel`; its output is combinational RGB.
- The top level owns the FSM, counters, LFSR register and output registers.

## Test plan
Unless stated, the bench uses IMG_WIDTH = 8, IMG_HEIGHT = 4, H_BLANK = 2, V_BLANK = 3.
- Single frame: `num_frames` = 1, `pattern_sel` = 0, `start` pulse. Required response:
  - 32 valid pixels and a 41-cycle frame.
  - Pixel x = k carries bar k colour.
  - `sof` at (0,0), `eof` at (7,3), `seq_done` 3 cycles after `eof`.
- Ramp: `pattern_sel` = 1. Pixel (5,2) = R 05, G 02, B 07. A receive-side coordinate monitor reports the same x/y as `x_coord`/`y_coord` for all 32 pixels.
- Hold: `hold` high for 3 cycles during pixel (3,1). Required response:
  - `valid` low for exactly 3 cycles.
  - The next pixel is (4,1) with unchanged data.
  - Frame length is 44.
- LFSR: `pattern_sel` = 3, `num_frames` = 2. The first pixel of both frames is AC/E1/B5, and the two frames' sequences are identical.
- Reset and start filtering:
  - Reset asserted at pixel (2,2): all outputs 0 on the next edge.
  - A later `start` begins cleanly at (0,0).
  - `start` pulsed while `busy` is ignored.
- Continuous mode: `num_frames` = 0. Required response:
  - 5 consecutive frames, with `sof` spacing of 41 cycles.
  - No `seq_done`, and `busy` stays high.
